// File: rtl/alu_pkg.sv
// Shared definitions for the vector-ALU issue controller: opcode, function
// codes, element-width encodings, FSM state encoding and the legality rule.
package alu_pkg;

  localparam logic [0:5] OPC_VEC   = 6'b101010;

  localparam logic [0:5] FUNC_VAND = 6'd1;
  localparam logic [0:5] FUNC_VOR  = 6'd2;
  localparam logic [0:5] FUNC_VXOR = 6'd3;
  localparam logic [0:5] FUNC_VNOT = 6'd4;
  localparam logic [0:5] FUNC_VMOV = 6'd5;

  localparam logic [0:1] WW_BYTE   = 2'b00;
  localparam logic [0:1] WW_HALF   = 2'b01;
  localparam logic [0:1] WW_WORD   = 2'b10;
  localparam logic [0:1] WW_DOUBLE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_e;

  // Only the vector opcode with one of the five supported functions is accepted.
  function automatic logic is_legal(input logic [0:5] opcode, input logic [0:5] func);
    logic ok;
    ok = 1'b0;
    if (opcode == OPC_VEC) begin
      case (func)
        FUNC_VAND, FUNC_VOR, FUNC_VXOR, FUNC_VNOT, FUNC_VMOV: ok = 1'b1;
        default: ok = 1'b0;
      endcase
    end else begin
      ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/alu_instr_decode.sv
// Combinational instruction field splitter and legality flag.
// Bit 0 of the instruction word is the MSB.
module alu_instr_decode
  import alu_pkg::*;
(
  input  logic [0:31] instr,
  output logic [0:4]  rd,
  output logic [0:4]  ra,
  output logic [0:4]  rb,
  output logic [0:1]  ww,
  output logic [0:5]  func,
  output logic        legal
);

  logic [0:5] opcode_s;
  logic [0:2] rsvd_unused_s;

  assign opcode_s      = instr[0:5];
  assign rd            = instr[6:10];
  assign ra            = instr[11:15];
  assign rb            = instr[16:20];
  assign rsvd_unused_s = instr[21:23];
  assign ww            = instr[24:25];
  assign func          = instr[26:31];
  assign legal         = is_legal(opcode_s, instr[26:31]);

endmodule

// File: rtl/alu_issue_ctrl.sv
// Single-issue controller: decode, register-file read, drive the external ALU,
// then hold the result on the write-back port until the consumer takes it.
module alu_issue_ctrl
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [0:31] instr,
  output logic        instr_ready,
  output logic [0:4]  rf_addr_a,
  output logic [0:4]  rf_addr_b,
  input  logic [0:63] rf_data_a,
  input  logic [0:63] rf_data_b,
  output logic [0:63] alu_rA,
  output logic [0:63] alu_rB,
  output logic [0:5]  alu_R_ins,
  output logic [0:5]  alu_Op_code,
  output logic [0:1]  alu_WW,
  input  logic [0:63] alu_result,
  output logic        wb_valid,
  output logic [0:4]  wb_addr,
  output logic [0:63] wb_data,
  input  logic        wb_ready,
  output logic        err_illegal,
  output logic [0:15] retire_count
);

  state_e      state_r, state_s;
  logic [0:4]  rd_s, ra_s, rb_s;
  logic [0:1]  ww_s;
  logic [0:5]  func_s;
  logic        legal_s, accept_s;

  logic [0:4]  rd_r, addr_a_r, addr_b_r;
  logic [0:1]  ww_r, alu_ww_r;
  logic [0:5]  func_r, alu_rins_r, alu_op_r;
  logic [0:63] opa_r, opb_r, wb_data_r;
  logic [0:4]  wb_addr_r;
  logic        wb_valid_r, err_r;
  logic [0:15] retire_count_r;

  alu_instr_decode u_decode (
    .instr (instr),
    .rd    (rd_s),
    .ra    (ra_s),
    .rb    (rb_s),
    .ww    (ww_s),
    .func  (func_s),
    .legal (legal_s)
  );

  assign accept_s = instr_valid && (state_r == ST_IDLE);

  // The register file samples its address on the accept edge, so the read
  // address bypasses the holding register during the accept cycle.
  assign rf_addr_a    = (accept_s && legal_s) ? ra_s : addr_a_r;
  assign rf_addr_b    = (accept_s && legal_s) ? rb_s : addr_b_r;
  assign instr_ready  = (state_r == ST_IDLE);
  assign alu_rA       = opa_r;
  assign alu_rB       = opb_r;
  assign alu_R_ins    = alu_rins_r;
  assign alu_Op_code  = alu_op_r;
  assign alu_WW       = alu_ww_r;
  assign wb_valid     = wb_valid_r;
  assign wb_addr      = wb_addr_r;
  assign wb_data      = wb_data_r;
  assign err_illegal  = err_r;
  assign retire_count = retire_count_r;

  // Next-state logic for the IDLE/READ/EXEC/WB sequence.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && legal_s) state_s = ST_READ;
        else                     state_s = ST_IDLE;
      end
      ST_READ: state_s = ST_EXEC;
      ST_EXEC: state_s = ST_WB;
      ST_WB: begin
        if (wb_ready) state_s = ST_IDLE;
        else          state_s = ST_WB;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register plus all datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      rd_r           <= 5'd0;
      addr_a_r       <= 5'd0;
      addr_b_r       <= 5'd0;
      ww_r           <= 2'd0;
      func_r         <= 6'd0;
      opa_r          <= 64'd0;
      opb_r          <= 64'd0;
      alu_op_r       <= 6'd0;
      alu_rins_r     <= 6'd0;
      alu_ww_r       <= 2'd0;
      wb_valid_r     <= 1'b0;
      wb_addr_r      <= 5'd0;
      wb_data_r      <= 64'd0;
      err_r          <= 1'b0;
      retire_count_r <= 16'd0;
    end else begin
      state_r <= state_s;
      err_r   <= accept_s && !legal_s;
      case (state_r)
        ST_IDLE: begin
          if (accept_s && legal_s) begin
            rd_r     <= rd_s;
            ww_r     <= ww_s;
            func_r   <= func_s;
            addr_a_r <= ra_s;
            addr_b_r <= rb_s;
          end
        end
        ST_READ: begin
          opa_r      <= rf_data_a;
          opb_r      <= rf_data_b;
          alu_op_r   <= OPC_VEC;
          alu_rins_r <= func_r;
          alu_ww_r   <= ww_r;
        end
        ST_EXEC: begin
          alu_op_r   <= 6'd0;
          alu_rins_r <= 6'd0;
          alu_ww_r   <= 2'd0;
          wb_data_r  <= alu_result;
          wb_addr_r  <= rd_r;
          wb_valid_r <= 1'b1;
        end
        ST_WB: begin
          if (wb_ready) begin
            wb_valid_r     <= 1'b0;
            retire_count_r <= retire_count_r + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: instr_valid  input  1  instruction offered.
REQ-004 SHALL have port: instr  input  [0:31]  instruction word, bit 0 = MSB.
REQ-005 SHALL have port: instr_ready  output  1  instruction accepted when instr_valid & instr_ready.
REQ-006 SHALL have ports: rf_addr_a, rf_addr_b  output  [0:4]  register-file read addresses.
REQ-007 SHALL have ports: rf_data_a, rf_data_b  input  [0:63]  read data, valid one cycle after address.
REQ-008 SHALL have ports: alu_rA, alu_rB  output  [0:63]; alu_R_ins, alu_Op_code  output  [0:5]; alu_WW  output  [0:1]; all drive the ALU.
REQ-009 SHALL have port: alu_result  input  [0:63]  combinational ALU output.
REQ-010 SHALL have ports: wb_valid  output  1; wb_addr  output  [0:4]; wb_data  output  [0:63]; wb_ready  input  1.
REQ-011 SHALL have port: err_illegal  output  1  one-cycle pulse on rejected instruction.
REQ-012 SHALL have port: retire_count  output  [0:15]  retired-instruction counter.

Function
REQ-013 Decode SHALL be: opcode instr[0:5], rD [6:10], rA [11:15], rB [16:20], WW [24:25], func [26:31]; bits [21:23] ignored.
REQ-014 Legal SHALL be opcode 6'b101010 with func 1 (VAND), 2 (VOR), 3 (VXOR), 4 (VNOT), 5 (VMOV); all else illegal.
REQ-015 FSM states SHALL be IDLE, READ, EXEC, WB.
REQ-016 instr_ready SHALL be 1 only in IDLE.
REQ-017 IDLE: on accept of legal instruction, latch rD/WW/func, drive rf_addr_a=rA, rf_addr_b=rB, go READ.
REQ-018 IDLE: on accept of illegal instruction, pulse err_illegal next cycle, stay IDLE, no write-back, no count.
REQ-019 READ: capture rf_data_a/b into operand registers, go EXEC.
REQ-020 EXEC: alu_rA/alu_rB = captured operands, alu_Op_code=6'b101010, alu_R_ins=func, alu_WW=WW; register alu_result into wb_data at cycle end; go WB.
REQ-021 Outside EXEC, alu_Op_code, alu_R_ins, alu_WW SHALL be 0; alu_rA/alu_rB hold last operands.
REQ-022 WB: wb_valid=1, wb_addr=rD; wb_addr/wb_data SHALL stay stable until wb_ready sampled high.
REQ-023 WB with wb_ready=1: retire, retire_count += 1 (wraps 16'hFFFF -> 0), go IDLE.
REQ-024 Latency: accept at cycle N -> wb_valid first high at cycle N+3; max throughput one instruction per 4 cycles.
REQ-025 instr_valid while not IDLE SHALL be ignored (not accepted, no error).
REQ-026 No operand forwarding needed; one instruction in flight at a time.

Reset
REQ-027 reset high at any rising edge SHALL force IDLE, discarding any in-flight instruction without write-back.
REQ-028 Reset values: instr_ready=1 after release, wb_valid=0, wb_addr=0, wb_data=0, err_illegal=0, retire_count=0, alu_* =0, rf_addr_*=0.

Structure
REQ-029 Shared package alu_pkg SHALL hold opcode 6'b101010, func codes 1-5, WW encodings (00 byte, 01 half, 10 word, 11 double), FSM state encoding.
REQ-030 One combinational sub-module alu_instr_decode SHALL split fields and flag legality; the ALU itself stays external.

Verification
REQ-031 VAND rA=15, rB=14, WW=10, rD=3, wb_ready=1 -> wb_valid at N+3, wb_addr=3, wb_data=64'd14, retire_count=1.
REQ-032 VNOT with rf_data_a=0 -> wb_data=64'hFFFFFFFF_FFFFFFFF; VMOV with 64'hFFFFFFFF_00000000 -> identical wb_data.
REQ-033 wb_ready low 3 cycles in WB -> wb_valid, wb_addr, wb_data stable; instr_ready=0; retire on 4th cycle.
REQ-034 instr opcode 6'b000000, or func 6'd9 -> err_illegal single pulse, no wb_valid, instr_ready stays 1, count unchanged.
REQ-035 reset asserted during EXEC -> next cycle all outputs at reset values, no wb_valid; following VOR 15,14 -> wb_data=64'd15.
REQ-036 Four back-to-back legal instructions with instr_valid held high -> accepts exactly every 4 cycles, retire_count=4; preload 16'hFFFF -> wraps to 0.
